// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial adder scheduler.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/serial_add_sched_if.sv
// Request/response handshake bundle for serial_add_sched.
// SERADD_SUB_EN adds per-requester subtract flags.
interface serial_add_sched_if #(
  parameter int unsigned WIDTH = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
`ifdef SERADD_SUB_EN
  logic             req0_sub;
  logic             req1_sub;
`endif
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_id;

`ifdef SERADD_SUB_EN
  modport master (
    output req0_valid, req0_a, req0_b, req0_sub, req1_valid, req1_a, req1_b, req1_sub,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub, req1_valid, req1_a, req1_b, req1_sub,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );
`else
  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );
  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );
`endif

endinterface

// File: rtl/serial_add_bit.sv
// One-bit full adder with a carry flop; clr presets the carry to init.
module serial_add_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic init,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  logic carry_q;

  assign s = a ^ b ^ carry_q;
  assign c = (a & b) | (carry_q & (a ^ b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (clr) begin
      carry_q <= init;
    end else if (en) begin
      carry_q <= c;
    end
  end

endmodule

// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one bit-serial adder between two requesters.
// SERADD_SUB_EN enables A-B operations via the requesters' sub flags.
module serial_add_sched
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_sched_if.slave bus,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q;
  logic             rsp_valid_q, rsp_cout_q, rsp_id_q, last_grant_q, sub_q;
  logic             take, take_id, grant_sub, b_bit, s_bit, c_bit;

  assign bus.req0_ready = (state_q == IDLE) & bus.req0_valid &
                          (!bus.req1_valid | (last_grant_q != REQ0));
  assign bus.req1_ready = (state_q == IDLE) & bus.req1_valid &
                          (!bus.req0_valid | (last_grant_q != REQ1));
  assign take    = bus.req0_ready | bus.req1_ready;
  assign take_id = bus.req1_ready ? REQ1 : REQ0;

`ifdef SERADD_SUB_EN
  assign grant_sub = bus.req1_ready ? bus.req1_sub : bus.req0_sub;
`else
  assign grant_sub = 1'b0;
`endif

  // Subtraction is A + ~B + 1: invert B bits, carry preset comes from grant_sub.
  assign b_bit = b_q[0] ^ sub_q;

  serial_add_bit u_bit (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (take),
    .init (grant_sub),
    .en   (state_q == SHIFT),
    .a    (a_q[0]),
    .b    (b_bit),
    .s    (s_bit),
    .c    (c_bit)
  );

  always_comb begin
    sum_d = sum_q;
    for (int i = 0; i < int'(WIDTH) - 1; i++) begin
      sum_d[i] = sum_q[i+1];
    end
    sum_d[WIDTH-1] = s_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      cnt_q        <= '0;
      sub_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_cout_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
      last_grant_q <= REQ1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (take) begin
            a_q          <= take_id ? bus.req1_a : bus.req0_a;
            b_q          <= take_id ? bus.req1_b : bus.req0_b;
            sub_q        <= grant_sub;
            cnt_q        <= '0;
            rsp_id_q     <= take_id;
            last_grant_q <= take_id;
            state_q      <= SHIFT;
          end
        end
        SHIFT: begin
          sum_q <= sum_d;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LastCnt) begin
            rsp_valid_q <= 1'b1;
            rsp_cout_q  <= c_bit;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed bench for serial_add_sched at WIDTH=4 with hand-computed results.
module tb_serial_add_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   n_checks = 0;
  int   n_fail = 0;

  serial_add_sched_if #(.WIDTH(4)) bus ();

  serial_add_sched #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic who, input logic [3:0] a, input logic [3:0] b);
    if (who) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  task automatic clr_req(input logic who);
    if (who) bus.req1_valid = 1'b0;
    else     bus.req0_valid = 1'b0;
  endtask

  function automatic logic rdy(input logic who);
    return who ? bus.req1_ready : bus.req0_ready;
  endfunction

  task automatic wait_grant(input logic who);
    for (int i = 0; i < 20; i++) begin
      if (rdy(who)) break;
      tick();
    end
    check("grant", 32'(rdy(who)), 32'd1);
  endtask

  // One complete operation: handshake, WIDTH-cycle latency, response, release.
  task automatic run_op(input logic who, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_sum, input logic exp_cout);
    set_req(who, a, b);
    #1;
    wait_grant(who);
    tick();
    clr_req(who);
    check("busy_hs", 32'(busy), 32'd1);
    repeat (3) begin
      tick();
      check("lat_lo", 32'(bus.rsp_valid), 32'd0);
      check("busy_sh", 32'(busy), 32'd1);
    end
    tick();
    check("lat_hi", 32'(bus.rsp_valid), 32'd1);
    check("sum", 32'(bus.rsp_sum), 32'(exp_sum));
    check("cout", 32'(bus.rsp_cout), 32'(exp_cout));
    check("id", 32'(bus.rsp_id), 32'(who));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready = 1'b0;
`ifdef SERADD_SUB_EN
    bus.req0_sub = 1'b0;
    bus.req1_sub = 1'b0;
`endif
    repeat (2) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_sum", 32'(bus.rsp_sum), 32'd0);
    check("rst_cout", 32'(bus.rsp_cout), 32'd0);
    check("rst_id", 32'(bus.rsp_id), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: 1000 + 0110
    run_op(1'b0, 4'b1000, 4'b0110, 4'b1110, 1'b0);
    // 2: carry out, then all zero
    run_op(1'b1, 4'b1111, 4'b0001, 4'b0000, 1'b1);
    run_op(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // 3: both continuously valid -> alternate starting with req0
    set_req(1'b0, 4'd3, 4'd2);
    set_req(1'b1, 4'd4, 4'd4);
    #1;
    for (int k = 0; k < 4; k++) begin
      logic exp_who;
      exp_who = k[0];
      for (int i = 0; i < 20; i++) begin
        if (bus.req0_ready || bus.req1_ready) break;
        tick();
      end
      check("excl", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
      check("rr_ready", 32'(rdy(exp_who)), 32'd1);
      tick();
      for (int i = 0; i < 20; i++) begin
        check("excl_run", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
        if (bus.rsp_valid) break;
        tick();
      end
      check("rr_valid", 32'(bus.rsp_valid), 32'd1);
      check("rr_id", 32'(bus.rsp_id), 32'(exp_who));
      check("rr_sum", 32'(bus.rsp_sum), exp_who ? 32'd8 : 32'd5);
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
    end
    clr_req(1'b0);
    clr_req(1'b1);

    // 4: response backpressure in DONE
    set_req(1'b0, 4'd1, 4'd2);
    #1;
    wait_grant(1'b0);
    tick();
    clr_req(1'b0);
    set_req(1'b1, 4'd5, 4'd5);
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_sum", 32'(bus.rsp_sum), 32'd3);
      check("bp_cout", 32'(bus.rsp_cout), 32'd0);
      check("bp_id", 32'(bus.rsp_id), 32'd0);
      check("bp_ready", 32'(bus.req1_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("bp_idle", 32'(busy), 32'd0);
    check("bp_accept", 32'(bus.req1_ready), 32'd1);
    clr_req(1'b1);

    // 5: reset during second SHIFT cycle
    set_req(1'b1, 4'b1111, 4'b1111);
    #1;
    wait_grant(1'b1);
    tick();
    clr_req(1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
    set_req(1'b0, 4'b0011, 4'b0101);
    set_req(1'b1, 4'b0001, 4'b0001);
    #1;
    check("tie_r0", 32'(bus.req0_ready), 32'd1);
    check("tie_r1", 32'(bus.req1_ready), 32'd0);
    clr_req(1'b1);
    run_op(1'b0, 4'b0011, 4'b0101, 4'b1000, 1'b0);

`ifdef SERADD_SUB_EN
    // 6: subtraction
    bus.req0_sub = 1'b1;
    run_op(1'b0, 4'b0110, 4'b1000, 4'b1110, 1'b0);
    run_op(1'b0, 4'b1000, 4'b0110, 4'b0010, 1'b1);
    bus.req0_sub = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
